bcrypt_b64_encoder: RTL and testbench

//  Synthesizable successor to the bench-side base64 dump of the bcrypt hash.
//  - Takes cost, salt and the truncated ciphertext from output_rst.
//  - Streams the modular-crypt string ("$2a$NN$" + salt chars + hash chars) one ASCII byte/cycle.
//  - Output is a valid/ready byte stream; feeds the UART TX path.
//  - Generalised over salt/hash byte counts, alphabet, version char and header enable.

---
 rtl/bcrypt_b64_encoder_if.sv | 29 ++
 rtl/bcrypt_b64_encoder.sv | 190 +++++++++++++++++++
 tb/tb_bcrypt_b64_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcrypt_b64_encoder_if.sv
// Load and character-stream signals of the bcrypt base64 encoder.
// master: the encoder side; slave: the producer of the load and consumer of the characters.
interface bcrypt_b64_encoder_if #(
    parameter int unsigned SALT_BYTES = 16,
    parameter int unsigned HASH_BYTES = 23
);
    localparam int SALT_W = (SALT_BYTES == 0) ? 1 : 8 * SALT_BYTES;
    localparam int HASH_W = (HASH_BYTES == 0) ? 1 : 8 * HASH_BYTES;

    logic              load_valid;
    logic              load_ready;
    logic [5:0]        cost;
    logic [SALT_W-1:0] salt;
    logic [HASH_W-1:0] hash;
    logic              char_valid;
    logic              char_ready;
    logic [7:0]        char_data;
    logic              char_last;

    modport master (
        input  load_valid, cost, salt, hash, char_ready,
        output load_ready, char_valid, char_data, char_last
    );

    modport slave (
        output load_valid, cost, salt, hash, char_ready,
        input  load_ready, char_valid, char_data, char_last
    );
endinterface

// File: rtl/bcrypt_b64_encoder.sv
// Streams the modular-crypt string "$2<ver>$NN$" + salt chars + hash chars, one ASCII byte
// per valid/ready handshake. Characters come from a per-section shift register whose top
// six bits index the selected base64 alphabet; tail groups are zero-padded, no '=' chars.
module bcrypt_b64_encoder #(
    parameter int unsigned SALT_BYTES  = 16,
    parameter int unsigned HASH_BYTES  = 23,
    parameter int unsigned ALPHABET    = 0,
    parameter bit          EMIT_HEADER = 1'b1,
    parameter logic [7:0]  VERSION     = 8'h61
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bcrypt_b64_encoder_if.master bus_io,
    output logic                 busy_o,
    output logic                 cost_warn_o
);
    localparam int SALT_CHARS = (8 * SALT_BYTES + 5) / 6;
    localparam int HASH_CHARS = (8 * HASH_BYTES + 5) / 6;
    localparam int SALT_W     = (SALT_BYTES == 0) ? 1 : 8 * SALT_BYTES;
    localparam int HASH_W     = (HASH_BYTES == 0) ? 1 : 8 * HASH_BYTES;
    localparam int SEC_CHARS  = (SALT_CHARS > HASH_CHARS) ? SALT_CHARS : HASH_CHARS;
    localparam int SHR_W      = (SEC_CHARS == 0) ? 6 : 6 * SEC_CHARS;
    localparam int MAX_CHARS  = (SEC_CHARS > 7) ? SEC_CHARS : 7;
    localparam int CNT_W      = $clog2(MAX_CHARS + 1);

    typedef enum logic [1:0] {StIdle, StHdr, StSalt, StHash} state_e;

    // Section entered after the header (or directly at load when no header is emitted).
    localparam state_e FirstSect = (SALT_CHARS > 0) ? StSalt :
                                   ((HASH_CHARS > 0) ? StHash : StIdle);
    localparam state_e AfterSalt = (HASH_CHARS > 0) ? StHash : StIdle;

    state_e              state_q, state_d, nxt_st;
    logic [CNT_W-1:0]    cnt_q, cnt_d, nxt_cnt;
    logic [SHR_W-1:0]    shr_q, shr_d;
    logic [5:0]          cost_q, cost_d;
    logic [SALT_W-1:0]   salt_q, salt_d, salt_src;
    logic [HASH_W-1:0]   hash_q, hash_d, hash_src;
    logic                warn_q, warn_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                last_q, last_d;
    logic                load_fire, char_fire, advance;
    logic [SHR_W-1:0]    salt_al, hash_al;

    function automatic logic [7:0] b64_char(input logic [5:0] v);
        logic [7:0] w;
        logic [7:0] c;
        w = {2'b00, v};
        if (ALPHABET == 0) begin
            if (v < 6'd2)        c = w + 8'd46;   // '.' '/'
            else if (v < 6'd28)  c = w + 8'd63;   // 'A'..'Z'
            else if (v < 6'd54)  c = w + 8'd69;   // 'a'..'z'
            else                 c = w - 8'd6;    // '0'..'9'
        end else begin
            if (v < 6'd26)       c = w + 8'd65;
            else if (v < 6'd52)  c = w + 8'd71;
            else if (v < 6'd62)  c = w - 8'd4;
            else if (v == 6'd62) c = 8'd43;       // '+'
            else                 c = 8'd47;       // '/'
        end
        return c;
    endfunction

    function automatic logic [7:0] hdr_char(input logic [CNT_W-1:0] idx, input logic [5:0] cost);
        logic [7:0] c;
        case (int'(idx))
            1:       c = 8'h32;
            2:       c = VERSION;
            4:       c = 8'h30 + {2'b00, cost / 6'd10};
            5:       c = 8'h30 + {2'b00, cost % 6'd10};
            default: c = 8'h24;
        endcase
        return c;
    endfunction

    assign load_fire = bus_io.load_valid && bus_io.load_ready;
    assign char_fire = valid_q && bus_io.char_ready;

    // At load the payload has not reached the registers yet, so sections entered in that
    // cycle take their bits straight from the bus.
    assign salt_src = load_fire ? bus_io.salt : salt_q;
    assign hash_src = load_fire ? bus_io.hash : hash_q;
    assign salt_al  = SHR_W'(salt_src) << (SHR_W - SALT_W);
    assign hash_al  = SHR_W'(hash_src) << (HASH_W > SHR_W ? 0 : SHR_W - HASH_W);

    // Next position in the string and the registered character presented there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shr_d   = shr_q;
        cost_d  = cost_q;
        salt_d  = salt_q;
        hash_d  = hash_q;
        warn_d  = warn_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        nxt_st  = state_q;
        nxt_cnt = cnt_q;
        advance = 1'b0;

        if (load_fire) begin
            cost_d  = bus_io.cost;
            salt_d  = bus_io.salt;
            hash_d  = bus_io.hash;
            warn_d  = (bus_io.cost < 6'd4) || (bus_io.cost > 6'd31);
            advance = 1'b1;
            nxt_cnt = '0;
            nxt_st  = EMIT_HEADER ? StHdr : FirstSect;
        end else if (char_fire) begin
            advance = 1'b1;
            nxt_cnt = cnt_q + CNT_W'(1);
            case (state_q)
                StHdr: if (cnt_q == CNT_W'(6)) begin
                    nxt_st  = FirstSect;
                    nxt_cnt = '0;
                end
                StSalt: if (cnt_q == CNT_W'(SALT_CHARS - 1)) begin
                    nxt_st  = AfterSalt;
                    nxt_cnt = '0;
                end
                StHash: if (cnt_q == CNT_W'(HASH_CHARS - 1)) begin
                    nxt_st  = StIdle;
                    nxt_cnt = '0;
                end
                default: begin
                    nxt_st  = StIdle;
                    nxt_cnt = '0;
                end
            endcase
        end

        if (advance) begin
            state_d = nxt_st;
            cnt_d   = nxt_cnt;
            valid_d = (nxt_st != StIdle);
            data_d  = 8'h00;
            last_d  = 1'b0;
            case (nxt_st)
                StHdr: data_d = hdr_char(nxt_cnt, cost_d);
                StSalt: begin
                    shr_d  = (state_q == StSalt) ? (shr_q << 6) : salt_al;
                    data_d = b64_char(shr_d[SHR_W-1 -: 6]);
                    last_d = (HASH_CHARS == 0) && (nxt_cnt == CNT_W'(SALT_CHARS - 1));
                end
                StHash: begin
                    shr_d  = (state_q == StHash) ? (shr_q << 6) : hash_al;
                    data_d = b64_char(shr_d[SHR_W-1 -: 6]);
                    last_d = (nxt_cnt == CNT_W'(HASH_CHARS - 1));
                end
                default: ;
            endcase
        end
    end

    // State, payload and output registers; reset aborts any string in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shr_q   <= '0;
            cost_q  <= '0;
            salt_q  <= '0;
            hash_q  <= '0;
            warn_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shr_q   <= shr_d;
            cost_q  <= cost_d;
            salt_q  <= salt_d;
            hash_q  <= hash_d;
            warn_q  <= warn_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign bus_io.load_ready = (state_q == StIdle) && !rst_i;
    assign bus_io.char_valid = valid_q;
    assign bus_io.char_data  = data_q;
    assign bus_io.char_last  = last_q;
    assign busy_o            = (state_q != StIdle);
    assign cost_warn_o       = warn_q;
endmodule

// File: tb/tb_bcrypt_b64_encoder.sv
// Scoreboard bench: expected strings are queued at load time, monitors pop on every handshake.
module tb_bcrypt_b64_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_a, busy_b, busy_c, warn_a, warn_b, warn_c;
    int   checks = 0;
    int   errors = 0;
    bit   rnd_mode = 1'b0;

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] q_c[$];

    always #5 clk = ~clk;

    bcrypt_b64_encoder_if if_a ();
    bcrypt_b64_encoder_if if_b ();
    bcrypt_b64_encoder_if if_c ();

    bcrypt_b64_encoder #(.ALPHABET(0)) u_a (
        .clk_i(clk), .rst_i(rst), .bus_io(if_a), .busy_o(busy_a), .cost_warn_o(warn_a)
    );
    bcrypt_b64_encoder #(.ALPHABET(1)) u_b (
        .clk_i(clk), .rst_i(rst), .bus_io(if_b), .busy_o(busy_b), .cost_warn_o(warn_b)
    );
    bcrypt_b64_encoder #(.EMIT_HEADER(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst), .bus_io(if_c), .busy_o(busy_c), .cost_warn_o(warn_c)
    );

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic string rep(string c, int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, c};
        return s;
    endfunction

    // Reference encoder working bit by bit from the MSB of the used bytes.
    function automatic string b64(logic [183:0] d, int nbytes, int alpha);
        string tbl;
        string s = "";
        int    nch = (8 * nbytes + 5) / 6;
        tbl = (alpha != 0) ? "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/"
                           : "./ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        for (int k = 0; k < nch; k++) begin
            int v = 0;
            for (int b = 0; b < 6; b++) begin
                int p = 6 * k + b;
                v = v * 2 + ((p < 8 * nbytes) ? int'(d[8 * nbytes - 1 - p]) : 0);
            end
            s = {s, tbl.substr(v, v)};
        end
        return s;
    endfunction

    function automatic string exp_str(int cost, logic [127:0] s, logic [183:0] h, int alpha,
                                      bit hdr);
        string r = hdr ? $sformatf("$2a$%0d%0d$", cost / 10, cost % 10) : "";
        return {r, b64({56'b0, s}, 16, alpha), b64(h, 23, alpha)};
    endfunction

    task automatic push_str(int dut, string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [8:0] e;
            e = {(i == s.len() - 1), s[i]};
            case (dut)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
    endtask

    task automatic drive(int dut, bit v, logic [5:0] c, logic [127:0] s, logic [183:0] h);
        case (dut)
            0: begin if_a.load_valid = v; if_a.cost = c; if_a.salt = s; if_a.hash = h; end
            1: begin if_b.load_valid = v; if_b.cost = c; if_b.salt = s; if_b.hash = h; end
            default: begin if_c.load_valid = v; if_c.cost = c; if_c.salt = s; if_c.hash = h; end
        endcase
    endtask

    function automatic bit lrdy(int dut);
        case (dut)
            0:       return if_a.load_ready;
            1:       return if_b.load_ready;
            default: return if_c.load_ready;
        endcase
    endfunction

    function automatic bit done(int dut);
        case (dut)
            0:       return if_a.char_valid && if_a.char_ready && if_a.char_last;
            1:       return if_b.char_valid && if_b.char_ready && if_b.char_last;
            default: return if_c.char_valid && if_c.char_ready && if_c.char_last;
        endcase
    endfunction

    task automatic load(int dut, logic [5:0] c, logic [127:0] s, logic [183:0] h);
        int n = 0;
        drive(dut, 1'b1, c, s, h);
        while (!lrdy(dut) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp($sformatf("load_accept_dut%0d", dut), int'(lrdy(dut)), 1);
        @(posedge clk);
        #1;
        drive(dut, 1'b0, c, s, h);
    endtask

    // Counts cycles from the first character to the char_last handshake.
    task automatic wait_done(int dut, int exp_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done(dut) && n < 2000);
        if (exp_cycles >= 0) cmp($sformatf("string_cycles_dut%0d", dut), n, exp_cycles);
        else cmp($sformatf("string_done_dut%0d", dut), int'(done(dut)), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic mon_pop(int dut, logic [8:0] act);
        logic [8:0] e;
        int sz;
        case (dut)
            0:       sz = q_a.size();
            1:       sz = q_b.size();
            default: sz = q_c.size();
        endcase
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char_dut%0d: got 0x%0h required none", dut, act);
        end else begin
            case (dut)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            cmp($sformatf("char_dut%0d", dut), int'(act), int'(e));
        end
    endtask

    // Ready generator: random 30% duty on DUT A when enabled, otherwise always ready.
    initial begin
        if_a.char_ready = 1'b1;
        if_b.char_ready = 1'b1;
        if_c.char_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if_a.char_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: pops and compares on every handshake, checks hold stability on DUT A stalls.
    initial begin
        bit         stalled = 1'b0;
        logic [7:0] hold_data = 8'h00;
        logic       hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    cmp("stall_hold", int'({if_a.char_valid, if_a.char_last, if_a.char_data}),
                        int'({1'b1, hold_last, hold_data}));
                if (if_a.char_valid && if_a.char_ready) mon_pop(0, {if_a.char_last, if_a.char_data});
                if (if_b.char_valid && if_b.char_ready) mon_pop(1, {if_b.char_last, if_b.char_data});
                if (if_c.char_valid && if_c.char_ready) mon_pop(2, {if_c.char_last, if_c.char_data});
                stalled   = if_a.char_valid && !if_a.char_ready;
                hold_data = if_a.char_data;
                hold_last = if_a.char_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s1, s2, s3, sff;
        logic [183:0] h1, h2, h3, hff;
        bit seen;
        int n;
        s1  = 128'h0123456789abcdeffedcba9876543210;
        h1  = 184'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69;
        s2  = 128'hdeadbeefcafef00d0011223344556677;
        h2  = 184'h8899aabbccddeeff00112233445566778899aabbccddee;
        s3  = 128'h55aa55aa00ff00ff1234567890abcdef;
        h3  = 184'hfedcba98765432100123456789abcdef13579bdf02468a;
        sff = '1;
        hff = '1;
        drive(0, 1'b0, 6'd0, '0, '0);
        drive(1, 1'b0, 6'd0, '0, '0);
        drive(2, 1'b0, 6'd0, '0, '0);

        // Reset values
        repeat (2) @(negedge clk);
        cmp("load_ready_in_rst", int'(if_a.load_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("rst_char_valid", int'(if_a.char_valid), 0);
        cmp("rst_char_data", int'(if_a.char_data), 0);
        cmp("rst_char_last", int'(if_a.char_last), 0);
        cmp("rst_busy", int'(busy_a), 0);
        cmp("rst_cost_warn", int'(warn_a), 0);
        cmp("rst_load_ready", int'(if_a.load_ready), 1);
        @(posedge clk);
        #1;

        // T1: all-zero payload, 60 chars in 60 cycles
        push_str(0, {"$2a$06$", rep(".", 53)});
        load(0, 6'd6, '0, '0);
        cmp("t1_cost_warn", int'(warn_a), 0);
        wait_done(0, 60);

        // T2: all-ones payload on both alphabets
        push_str(0, {"$2a$06$", rep("9", 21), "u", rep("9", 30), "6"});
        load(0, 6'd6, sff, hff);
        wait_done(0, 60);
        push_str(1, {"$2a$06$", rep("/", 21), "w", rep("/", 30), "8"});
        load(1, 6'd6, sff, hff);
        wait_done(1, 60);

        // T3: cost 31, same payload with full-rate ready then with random backpressure
        push_str(0, {"$2a$31$", b64({56'b0, s1}, 16, 0), b64(h1, 23, 0)});
        load(0, 6'd31, s1, h1);
        wait_done(0, 60);
        push_str(0, {"$2a$31$", b64({56'b0, s1}, 16, 0), b64(h1, 23, 0)});
        rnd_mode = 1'b1;
        load(0, 6'd31, s1, h1);
        wait_done(0, -1);
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;

        // T4: load_valid held high, payload changed during the first string
        push_str(0, exp_str(5, s1, h1, 0, 1'b1));
        push_str(0, exp_str(12, s2, h2, 0, 1'b1));
        drive(0, 1'b1, 6'd5, s1, h1);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 6'd12, s2, h2);
        seen = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (if_a.load_ready) seen = 1'b1;
        end while (!done(0) && n < 2000);
        cmp("t4_ready_low_while_busy", int'(seen), 0);
        cmp("t4_string1_cycles", n, 60);
        @(posedge clk);
        #1;
        cmp("t4_idle_load_ready", int'(if_a.load_ready), 1);
        cmp("t4_idle_busy", int'(busy_a), 0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 6'd0, '0, '0);
        cmp("t4_busy_after_reload", int'(busy_a), 1);
        wait_done(0, 60);

        // T5: reset while char 35 is presented
        push_str(0, exp_str(6, s3, h3, 0, 1'b1));
        load(0, 6'd6, s3, h3);
        repeat (34) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("t5_char_valid", int'(if_a.char_valid), 0);
        cmp("t5_busy", int'(busy_a), 0);
        cmp("t5_load_ready", int'(if_a.load_ready), 1);
        cmp("t5_chars_consumed", q_a.size(), 26);
        q_a.delete();
        push_str(0, exp_str(7, s3, h3, 0, 1'b1));
        load(0, 6'd7, s3, h3);
        wait_done(0, 60);

        // T6: out-of-range costs, and no header
        push_str(0, {"$2a$03$", b64({56'b0, s2}, 16, 0), b64(h2, 23, 0)});
        load(0, 6'd3, s2, h2);
        cmp("t6_warn_cost3", int'(warn_a), 1);
        wait_done(0, 60);
        cmp("t6_warn_held", int'(warn_a), 1);
        push_str(0, {"$2a$63$", b64({56'b0, s1}, 16, 0), b64(h1, 23, 0)});
        load(0, 6'd63, s1, h1);
        cmp("t6_warn_cost63", int'(warn_a), 1);
        wait_done(0, 60);
        push_str(0, {"$2a$04$", b64({56'b0, s3}, 16, 0), b64(h3, 23, 0)});
        load(0, 6'd4, s3, h3);
        cmp("t6_warn_cost4", int'(warn_a), 0);
        wait_done(0, 60);
        push_str(2, {b64({56'b0, s2}, 16, 0), b64(h2, 23, 0)});
        load(2, 6'd6, s2, h2);
        wait_done(2, 53);

        repeat (3) @(posedge clk);
        cmp("queue_a_empty", q_a.size(), 0);
        cmp("queue_b_empty", q_b.size(), 0);
        cmp("queue_c_empty", q_c.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
